// File: rtl/tictactoe_pkg.sv
// Shared definitions for the tic-tac-toe board stream receiver.
//   - cell codes as driven on the chip's xoroout pins
//   - board geometry
//   - receiver FSM state encoding
//   - bit positions inside err_flags
package tictactoe_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;
    localparam logic [1:0] CELL_BAD   = 2'b11;

    localparam int NUM_CELLS = 9;
    localparam int BOARD_W   = 2 * NUM_CELLS;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    localparam int ERR_CELL    = 0;
    localparam int ERR_REGRESS = 1;
    localparam int ERR_OVERRUN = 2;

endpackage

// File: rtl/rc_to_index.sv
// Row/column to linear cell index decode (row-major, index = row*3 + col).
//   row, col : 2-bit coordinates, value 3 is not a board position
//   idx      : 4-bit cell index, meaningful only when legal is high
//   legal    : both coordinates are inside the 3x3 board
module rc_to_index (
    input  logic [1:0] row,
    input  logic [1:0] col,
    output logic [3:0] idx,
    output logic       legal
);

    always_comb begin
        legal = (row != 2'd3) && (col != 2'd3);
        idx   = ({2'b00, row} * 4'd3) + {2'b00, col};
    end

endmodule

// File: rtl/board_stream_rx.sv
// Receiver for the chip's rotating board output stream.
// Aligns to the cell stream, rebuilds the 18-bit board in a shadow register,
// screens each finished frame for illegal cells and regressions, and after
// LOCK_FRAMES consecutive clean frames hands frames out over valid/ready.
//   clk, reset            : single clock, synchronous active-high reset
//   in_valid, xoro,row,col: incoming cell sample
//   board, change_mask,
//   restart, out_valid,
//   out_ready             : delivered frame and its handshake
//   locked                : alignment established
//   sync_err              : one-cycle pulse on a sequence break
//   err_flags, err_clr    : sticky {overrun, regress_err, cell_err} and clear
module board_stream_rx
    import tictactoe_pkg::*;
#(
    parameter int LOCK_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [1:0]           xoro,
    input  logic [1:0]           row,
    input  logic [1:0]           col,
    output logic [BOARD_W-1:0]   board,
    output logic [NUM_CELLS-1:0] change_mask,
    output logic                 restart,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 locked,
    output logic                 sync_err,
    output logic [2:0]           err_flags,
    input  logic                 err_clr
);

    localparam logic [2:0] LOCK_TGT = 3'(LOCK_FRAMES);

    rx_state_e              state_q, state_d;
    logic [3:0]             exp_q, exp_d;
    logic [BOARD_W-1:0]     shadow_q, shadow_d;
    logic                   bad_q, bad_d;
    logic [2:0]             lock_cnt_q, lock_cnt_d;
    logic                   locked_q, locked_d;
    logic [BOARD_W-1:0]     board_q, board_d;
    logic [NUM_CELLS-1:0]   change_q, change_d;
    logic                   restart_q, restart_d;
    logic                   out_valid_q, out_valid_d;
    logic                   sync_err_q, sync_err_d;
    logic [2:0]             err_q, err_d;

    logic [3:0]             idx;
    logic                   legal;

    logic                   start, accept, frame_done, cell_bad;
    logic                   regress_raw, regress, frame_empty, prev_empty;
    logic [NUM_CELLS-1:0]   chg_mask;
    logic [2:0]             cnt_nxt;

    rc_to_index u_rc_to_index (
        .row   (row),
        .col   (col),
        .idx   (idx),
        .legal (legal)
    );

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        shadow_d    = shadow_q;
        bad_d       = bad_q;
        lock_cnt_d  = lock_cnt_q;
        locked_d    = locked_q;
        board_d     = board_q;
        change_d    = change_q;
        restart_d   = restart_q;
        out_valid_d = out_valid_q;
        sync_err_d  = 1'b0;
        err_d       = err_q;

        cell_bad    = (xoro == CELL_BAD);
        start       = 1'b0;
        accept      = 1'b0;
        frame_done  = 1'b0;
        regress_raw = 1'b0;
        chg_mask    = '0;
        cnt_nxt     = lock_cnt_q;

        // Clear first so any flag-setting event below overrides it.
        if (err_clr)
            err_d = '0;

        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;

        if (in_valid) begin
            if (state_q == HUNT) begin
                start = legal && (idx == 4'd0);
            end else if (legal && (idx == exp_q)) begin
                accept = 1'b1;
            end else begin
                sync_err_d = 1'b1;
                lock_cnt_d = '0;
                locked_d   = 1'b0;
                // A break that lands on cell 0 is itself a valid frame start.
                if (legal && (idx == 4'd0)) begin
                    start = 1'b1;
                end else begin
                    state_d = HUNT;
                    exp_d   = 4'd0;
                end
            end
        end

        if (start) begin
            shadow_d = {{(BOARD_W-2){1'b0}}, xoro};
            bad_d    = cell_bad;
            exp_d    = 4'd1;
            state_d  = RECV;
        end

        if (accept) begin
            for (int k = 0; k < NUM_CELLS; k++)
                if (idx == 4'(k))
                    shadow_d[2*k +: 2] = xoro;
            // Cell 0 opens a new frame, so the bad marker of the old one is dropped.
            bad_d      = ((idx == 4'd0) ? 1'b0 : bad_q) | cell_bad;
            frame_done = (exp_q == 4'd8);
            exp_d      = frame_done ? 4'd0 : exp_q + 4'd1;
        end

        if ((start || accept) && cell_bad)
            err_d[ERR_CELL] = 1'b1;

        // Compare the frame being closed against the last delivered board.
        frame_empty = (shadow_d == '0);
        prev_empty  = (board_q == '0);
        for (int k = 0; k < NUM_CELLS; k++) begin
            if ((board_q[2*k +: 2] != CELL_EMPTY) && (shadow_d[2*k +: 2] != board_q[2*k +: 2]))
                regress_raw = 1'b1;
            if ((board_q[2*k +: 2] == CELL_EMPTY) && (shadow_d[2*k +: 2] != CELL_EMPTY))
                chg_mask[k] = 1'b1;
        end
        // An all-empty frame is the chip restarting its game, not a regression.
        regress = regress_raw && !frame_empty;

        if (frame_done) begin
            if (regress)
                err_d[ERR_REGRESS] = 1'b1;
            if (bad_d || regress) begin
                lock_cnt_d = '0;
                locked_d   = 1'b0;
            end else begin
                cnt_nxt    = (lock_cnt_q >= LOCK_TGT) ? LOCK_TGT : lock_cnt_q + 3'd1;
                lock_cnt_d = cnt_nxt;
                if (cnt_nxt == LOCK_TGT)
                    locked_d = 1'b1;
                if (locked_d) begin
                    if (out_valid_q && !out_ready) begin
                        err_d[ERR_OVERRUN] = 1'b1;
                    end else begin
                        board_d     = shadow_d;
                        change_d    = chg_mask;
                        restart_d   = frame_empty && !prev_empty;
                        out_valid_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            exp_q       <= '0;
            shadow_q    <= '0;
            bad_q       <= 1'b0;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            board_q     <= '0;
            change_q    <= '0;
            restart_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            shadow_q    <= shadow_d;
            bad_q       <= bad_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            board_q     <= board_d;
            change_q    <= change_d;
            restart_q   <= restart_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            err_q       <= err_d;
        end
    end

    assign board       = board_q;
    assign change_mask = change_q;
    assign restart     = restart_q;
    assign out_valid   = out_valid_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;
    assign err_flags   = err_q;

endmodule

// File: tb/tb_board_stream_rx.sv
// Bench for board_stream_rx: directed walk through the main scenarios, then a
// long randomized stream, every cycle compared against a frame-level model.
module tb_board_stream_rx;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready, err_clr;
    logic [1:0]  xoro, row, col;
    logic [17:0] board;
    logic [8:0]  change_mask;
    logic        restart, out_valid, locked, sync_err;
    logic [2:0]  err_flags;

    always #5 clk = ~clk;

    board_stream_rx #(.LOCK_FRAMES(L)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .xoro(xoro), .row(row), .col(col),
        .board(board), .change_mask(change_mask), .restart(restart),
        .out_valid(out_valid), .out_ready(out_ready),
        .locked(locked), .sync_err(sync_err),
        .err_flags(err_flags), .err_clr(err_clr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    int         m_cells[9];   // frame under construction
    int         m_board[9];   // last delivered board
    int         m_exp, m_cnt;
    bit         m_hunt, m_bad, m_locked, m_ov, m_rst, m_serr;
    logic [8:0] m_chg;
    logic [2:0] m_err;

    function automatic logic [17:0] m_pack();
        logic [17:0] b = '0;
        for (int k = 0; k < 9; k++) b[2*k +: 2] = 2'(m_board[k]);
        return b;
    endfunction

    task automatic model_reset();
        m_hunt = 1; m_exp = 0; m_bad = 0; m_cnt = 0; m_locked = 0;
        m_ov = 0; m_rst = 0; m_chg = '0; m_serr = 0; m_err = '0;
        for (int k = 0; k < 9; k++) begin m_cells[k] = 0; m_board[k] = 0; end
    endtask

    task automatic model_begin(input int x);
        for (int k = 0; k < 9; k++) m_cells[k] = 0;
        m_cells[0] = x; m_bad = (x == 3);
        if (x == 3) m_err[0] = 1;
        m_exp = 1; m_hunt = 0;
    endtask

    task automatic model_finish();
        bit empty = 1, regr = 0, prev_nonempty = 0;
        for (int k = 0; k < 9; k++) begin
            if (m_cells[k] != 0) empty = 0;
            if (m_board[k] != 0) prev_nonempty = 1;
            if (m_board[k] != 0 && m_cells[k] != m_board[k]) regr = 1;
        end
        if (empty) regr = 0;
        if (regr) m_err[1] = 1;
        if (m_bad || regr) begin
            m_cnt = 0; m_locked = 0;
        end else begin
            if (m_cnt < L) m_cnt++;
            if (m_cnt == L) m_locked = 1;
            if (m_locked) begin
                if (m_ov && !out_ready) m_err[2] = 1;
                else begin
                    for (int k = 0; k < 9; k++) begin
                        m_chg[k]   = (m_board[k] == 0) && (m_cells[k] != 0);
                        m_board[k] = m_cells[k];
                    end
                    m_rst = empty && prev_nonempty;
                    m_ov  = 1;
                end
            end
        end
    endtask

    task automatic model_step();
        int k; bit ok;
        if (reset) begin model_reset(); return; end
        m_serr = 0;
        if (err_clr) m_err = '0;
        if (m_ov && out_ready) m_ov = 0;
        if (!in_valid) return;
        ok = (row != 2'd3) && (col != 2'd3);
        k  = int'(row) * 3 + int'(col);
        if (m_hunt) begin
            if (ok && k == 0) model_begin(int'(xoro));
        end else if (ok && k == m_exp) begin
            if (k == 0) model_begin(int'(xoro));
            else begin
                m_cells[k] = int'(xoro);
                if (xoro == 2'd3) begin m_bad = 1; m_err[0] = 1; end
                m_exp++;
                if (m_exp == 9) begin m_exp = 0; model_finish(); end
            end
        end else begin
            m_serr = 1; m_cnt = 0; m_locked = 0;
            if (ok && k == 0) model_begin(int'(xoro));
            else begin m_hunt = 1; m_exp = 0; end
        end
    endtask

    task automatic compare_all();
        chk("board",       32'(board),       32'(m_pack()));
        chk("change_mask", 32'(change_mask), 32'(m_chg));
        chk("restart",     32'(restart),     32'(m_rst));
        chk("out_valid",   32'(out_valid),   32'(m_ov));
        chk("locked",      32'(locked),      32'(m_locked));
        chk("sync_err",    32'(sync_err),    32'(m_serr));
        chk("err_flags",   32'(err_flags),   32'(m_err));
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic cyc(input logic v, input logic [1:0] x, input logic [1:0] r, input logic [1:0] c,
                       input logic rdy, input logic clr, input logic rst);
        reset = rst; in_valid = v; xoro = x; row = r; col = c; out_ready = rdy; err_clr = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_frame(input logic [17:0] bd, input logic rdy_body, input logic rdy_last);
        for (int k = 0; k < 9; k++)
            cyc(1'b1, bd[2*k +: 2], 2'(k / 3), 2'(k % 3), (k == 8) ? rdy_last : rdy_body, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 2'd0, 2'd0, 2'd0, rdy, 1'b0, 1'b0);
    endtask

    // ---------------- random stream generator ----------------
    int g[9];
    int gp = 0;

    task automatic mutate();
        int roll = int'($urandom_range(0, 99));
        int k    = int'($urandom_range(0, 8));
        if (roll < 4) begin
            for (int i = 0; i < 9; i++) g[i] = 0;
        end else if (roll < 7) begin
            if (g[k] != 0) g[k] = 3 - g[k];
        end else if (roll < 40) begin
            if (g[k] == 0) g[k] = int'($urandom_range(1, 2));
        end
    endtask

    initial begin
        logic [17:0] bd;
        model_reset();
        reset = 1; in_valid = 0; xoro = 0; row = 0; col = 0; out_ready = 0; err_clr = 0;
        @(negedge clk);
        cyc(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_board", 32'(board), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err", 32'(err_flags), 32'd0);

        // Lock on an empty board: nothing after frame 1, delivery at end of frame 2.
        send_frame(18'h0, 1'b0, 1'b0);
        chk("lock_f1_valid", 32'(out_valid), 32'd0);
        send_frame(18'h0, 1'b0, 1'b0);
        chk("lock_f2_valid", 32'(out_valid), 32'd1);
        chk("lock_f2_locked", 32'(locked), 32'd1);
        idle(1'b1);
        chk("consume", 32'(out_valid), 32'd0);

        // X at (1,1).
        send_frame(18'h00100, 1'b1, 1'b0);
        chk("move_board", 32'(board), 32'h00100);
        chk("move_change", 32'(change_mask), 32'h010);
        chk("move_restart", 32'(restart), 32'd0);
        idle(1'b1);

        // Skip cell (1,2): break on sample (2,0).
        for (int k = 0; k < 9; k++) begin
            if (k == 5) continue;
            cyc(1'b1, (k == 4) ? 2'd1 : 2'd0, 2'(k / 3), 2'(k % 3), 1'b1, 1'b0, 1'b0);
            if (k == 6) begin
                chk("break_pulse", 32'(sync_err), 32'd1);
                chk("break_unlock", 32'(locked), 32'd0);
            end
        end
        send_frame(18'h00100, 1'b1, 1'b1);
        chk("relock_f1", 32'(out_valid), 32'd0);
        send_frame(18'h00100, 1'b1, 1'b1);
        chk("relock_f2", 32'(out_valid), 32'd1);
        idle(1'b1);

        // Illegal code at (2,0).
        send_frame(18'h03100, 1'b1, 1'b1);
        chk("bad_err", 32'(err_flags), 32'b001);
        chk("bad_unlock", 32'(locked), 32'd0);
        chk("bad_novalid", 32'(out_valid), 32'd0);
        cyc(1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("bad_clr", 32'(err_flags), 32'd0);

        // Regression X->O at cell 0, then chip reset to empty.
        send_frame(18'h00101, 1'b1, 1'b1);
        send_frame(18'h00101, 1'b1, 1'b1);
        idle(1'b1);
        send_frame(18'h00102, 1'b1, 1'b1);
        chk("regr_err", 32'(err_flags), 32'b010);
        chk("regr_novalid", 32'(out_valid), 32'd0);
        send_frame(18'h0, 1'b1, 1'b1);
        send_frame(18'h0, 1'b1, 1'b1);
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_flag", 32'(restart), 32'd1);
        chk("restart_board", 32'(board), 32'd0);
        cyc(1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);

        // Overrun: out_ready low across two completions.
        send_frame(18'h0, 1'b0, 1'b0);
        send_frame(18'h00001, 1'b0, 1'b0);
        chk("ovr_err", 32'(err_flags), 32'b100);
        chk("ovr_hold", 32'(board), 32'd0);
        chk("ovr_valid", 32'(out_valid), 32'd1);
        cyc(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        // Accept on the same edge as a completion.
        send_frame(18'h00001, 1'b0, 1'b1);
        chk("same_valid", 32'(out_valid), 32'd1);
        chk("same_board", 32'(board), 32'h00001);
        chk("same_change", 32'(change_mask), 32'h001);
        chk("same_err", 32'(err_flags), 32'd0);
        idle(1'b1);

        // Randomized stream.
        for (int i = 0; i < 9; i++) g[i] = 0;
        for (int n = 0; n < 6000; n++) begin
            logic v, rdy, clr, rst;
            logic [1:0] x, r, c;
            int p;
            rst = ($urandom_range(0, 999) < 3);
            v   = ($urandom_range(0, 99) < 90);
            rdy = ($urandom_range(0, 99) < 65);
            clr = ($urandom_range(0, 99) < 3);
            p   = gp;
            if ($urandom_range(0, 99) < 3) p = (gp + 1) % 9;
            r = 2'(p / 3);
            c = 2'(p % 3);
            x = 2'(g[p]);
            if ($urandom_range(0, 99) < 1) r = 2'd3;
            if ($urandom_range(0, 99) < 2) x = 2'd3;
            cyc(v, x, r, c, rdy, clr, rst);
            if (v) begin
                gp = (p + 1) % 9;
                if (gp == 0) mutate();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
